multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle sequencing FSM for the 16-bit MIPS-style datapath (4-bit opcode, 3-bit func, half-word load/store).
- Sequences datapath control one phase per cycle: fetch, decode, execute, memory, writeback.
- Shares a single unified memory port between instruction fetch and LHW/SHW data access through a req/ready handshake.
- Keeps retired-instruction and memory-stall counters for the debug/perf path.

Parameters:
CNT_W, 16, width of retired_cnt and stall_cnt

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
opcode  input  4  IR[15:12], stable from end of FETCH
func  input  3  IR[2:0], R-type function
equal  input  1  register-compare result, valid in EXEC
mem_ready  input  1  memory completes current request this cycle
mem_req  output  1  memory request
mem_we  output  1  write strobe (with mem_req)
iord  output  1  address select: 0=PC, 1=ALU result
ir_write  output  1  load IR
pc_write  output  1  load PC
pc_src  output  2  0=PC+2, 1=branch target, 2=jump target
alu_src_b  output  1  0=register, 1=sign-extended immediate
alu_control  output  4  ALU op code
reg_write  output  1  register file write enable
reg_dst  output  1  1=rd (R-type), 0=rt
mem_to_reg  output  1  1=writeback from memory data
instr_done  output  1  one-cycle pulse per retired instruction
illegal  output  1  sticky illegal-opcode flag
state  output  3  current state, for debug
retired_cnt  output  CNT_W  retired instructions, wraps
stall_cnt  output  CNT_W  mem_req && !mem_ready cycles, saturates

Behaviour:
- States and encoding:
  - RESET=0, FETCH=1, DECODE=2, EXEC=3, MEMACC=4, WB=5, TRAP=6.
- Reset (rst=0, asynchronous):
  - state=RESET.
  - Counters=0, illegal=0.
  - All other outputs 0.
  - RESET -> FETCH on the first clock edge after rst deasserts.
- Output decoding:
  - Outputs are combinational from state and opcode/func. Only state and counters are registered.
  - Any output not listed for a state is 0.
- FETCH:
  - Drives mem_req=1, iord=0.
  - While mem_ready=0: hold state.
  - On the mem_ready=1 cycle: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
  - Zero-wait (ready in the same cycle as req) is legal.
- DECODE: one cycle.
  - J (1111): pc_write=1, pc_src=2, instr_done=1; next FETCH.
  - Illegal opcode (0101, 0110, 1011–1110) or R-type with func=111: next TRAP.
  - Otherwise: next EXEC.
- EXEC, alu_control mapping:
  - ADD/ADDI/LHW/SHW -> 0.
  - SUB/SUBI/BEQ/BNE -> 1.
  - AND/ANDI -> 2.
  - OR/ORI -> 3.
  - XOR -> 4.
  - NOR -> 5.
  - SLT -> 6.
  - alu_control is 0 in all states except EXEC and MEMACC. MEMACC holds the EXEC value.
- EXEC, per instruction class:
  - R-type: alu_src_b=0; next WB.
  - ADDI/ANDI/ORI/SUBI: alu_src_b=1; next WB.
  - LHW/SHW: alu_src_b=1; next MEMACC.
  - BEQ/BNE: alu_src_b=0. Taken when equal=1 (BEQ) or equal=0 (BNE). If taken: pc_write=1, pc_src=1. Always instr_done=1; next FETCH.
- MEMACC:
  - Drives mem_req=1, iord=1, mem_we=(opcode==SHW).
  - Holds until mem_ready.
  - On ready, SHW: instr_done=1; next FETCH.
  - On ready, LHW: next WB.
- WB:
  - reg_write=1, reg_dst=(opcode==0000), mem_to_reg=(opcode==LHW), instr_done=1.
  - Next FETCH.
- TRAP:
  - illegal=1. All control strobes 0 (no PC/register/memory writes).
  - Stays in TRAP until reset.
- Counters:
  - retired_cnt += 1 on each instr_done cycle; wraps from all-ones to 0.
  - stall_cnt += 1 on each cycle with mem_req=1 and mem_ready=0; saturates at all-ones.
- Boundary conditions:
  - mem_ready while mem_req=0 is ignored.
  - Reset asserted mid-FETCH or mid-MEMACC aborts immediately: mem_req drops asynchronously and no write strobe completes.
  - Latency with zero-wait memory: R/I-arith 4 cycles; LHW 5; SHW 4; BEQ/BNE 3; J 2.

Test Plan:
1. Reset sequence: rst=0 for 3 cycles, then 1 -> all outputs 0 during reset; state 0->1 one edge after release; mem_req=1, iord=0 in FETCH.
2. ADD (opcode 0000, func 000), mem_ready tied 1 -> states 1,2,3,5; alu_control=0 in EXEC; reg_write=1, reg_dst=1 in WB; instr_done once; retired_cnt=1.
3. LHW (0111), 3 wait cycles at fetch and 2 at data -> FETCH held 4 cycles, MEMACC held 3 cycles with iord=1, mem_we=0; WB mem_to_reg=1; stall_cnt=5.
4. BEQ (1001), equal=1 then BNE (1010), equal=1 -> first: pc_write=1, pc_src=1 in EXEC. Second: pc_write=0 in EXEC. Both assert instr_done.
5. Illegal: opcode 1100, then R-type func 111 after reset -> state 6, illegal=1 held indefinitely, no pc_write/reg_write/mem_req; cleared only by rst=0.
6. Counter limits: preload near all-ones (CNT_W=4), 20 single-wait fetches -> stall_cnt sticks at 15; retired_cnt wraps 15->0; rst asserted mid-MEMACC SHW -> mem_we drops the same cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle fetch/decode/exec/mem/wb sequencer with shared memory port
module multicycle_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [2:0]       func,
  input  logic             equal,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_b,
  output logic [3:0]       alu_control,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEMACC = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_SUBI  = 4'b0010;
  localparam logic [3:0] OP_ANDI  = 4'b0011;
  localparam logic [3:0] OP_ORI   = 4'b0100;
  localparam logic [3:0] OP_LHW   = 4'b0111;
  localparam logic [3:0] OP_SHW   = 4'b1000;
  localparam logic [3:0] OP_BEQ   = 4'b1001;
  localparam logic [3:0] OP_BNE   = 4'b1010;
  localparam logic [3:0] OP_J     = 4'b1111;

  state_t     state_q, state_d;
  logic       bad_op;
  logic [3:0] alu_op;

  assign state = state_q;

  always_comb begin
    bad_op = 1'b0;
    case (opcode)
      4'b0101, 4'b0110, 4'b1011, 4'b1100, 4'b1101, 4'b1110: bad_op = 1'b1;
      OP_RTYPE: bad_op = (func == 3'b111);
      default:  bad_op = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = 4'd0;
    case (opcode)
      OP_RTYPE: alu_op = {1'b0, func};
      OP_SUBI, OP_BEQ, OP_BNE: alu_op = 4'd1;
      OP_ANDI: alu_op = 4'd2;
      OP_ORI:  alu_op = 4'd3;
      default: alu_op = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    alu_src_b   = 1'b0;
    alu_control = 4'd0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_J) begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (bad_op) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_control = alu_op;
        case (opcode)
          OP_RTYPE: state_d = S_WB;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_LHW, OP_SHW: begin
            alu_src_b = 1'b1;
            state_d   = S_MEMACC;
          end
          default: begin
            // only branches reach EXEC otherwise
            if ((opcode == OP_BEQ) == equal) begin
              pc_write = 1'b1;
              pc_src   = 2'd1;
            end
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMACC: begin
        alu_control = alu_op;
        mem_req     = 1'b1;
        iord        = 1'b1;
        mem_we      = (opcode == OP_SHW);
        if (mem_ready) begin
          if (opcode == OP_SHW) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        mem_to_reg = (opcode == OP_LHW);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  illegal = 1'b1;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (instr_done) retired_cnt <= retired_cnt + 1'b1;
      if (mem_req && !mem_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized trace-model bench for multicycle_controller
module tb_multicycle_controller;

  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       opcode;
  logic [2:0]       func;
  logic             equal;
  logic             mem_ready;
  logic             mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]       pc_src;
  logic             alu_src_b;
  logic [3:0]       alu_control;
  logic             reg_write, reg_dst, mem_to_reg, instr_done, illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired_cnt, stall_cnt;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .equal(equal),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal(illegal), .state(state), .retired_cnt(retired_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, we, iord, irw, pcw;
    logic [1:0] pcsrc;
    logic       asrcb;
    logic [3:0] alu;
    logic       rw, rdst, m2r, done, ill;
    logic [2:0] st;
  } ctl_t;

  ctl_t act;
  assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b,
                alu_control, reg_write, reg_dst, mem_to_reg, instr_done,
                illegal, state};

  int checks = 0;
  int failures = 0;
  int m_ret = 0;
  int m_stall = 0;
  bit trapped;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_illegal(input logic [3:0] op, input logic [2:0] fn);
    return (op inside {4'd5, 4'd6, 4'd11, 4'd12, 4'd13, 4'd14}) || (op == 4'd0 && fn == 3'd7);
  endfunction

  function automatic logic [3:0] alu_of(input logic [3:0] op, input logic [2:0] fn);
    case (op)
      4'd0: begin
        logic [3:0] r;
        r = {1'b0, fn};
        return r;
      end
      4'd2, 4'd9, 4'd10: return 4'd1;
      4'd3:    return 4'd2;
      4'd4:    return 4'd3;
      default: return 4'd0;
    endcase
  endfunction

  // one clock cycle: drive at negedge, check outputs and counters, then account for the coming edge
  task automatic cyc(input ctl_t x, input logic rdy, input logic [3:0] op, input logic eq, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = op;
    equal     = eq;
    #1;
    check({tag, "_ctl"}, 32'(act), 32'(x));
    check({tag, "_retired"}, 32'(retired_cnt), 32'(m_ret % (CMAX + 1)));
    check({tag, "_stall"}, 32'(stall_cnt), 32'(m_stall));
    if (x.done) m_ret++;
    if (x.req && !rdy && m_stall < CMAX) m_stall++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_ret = 0;
    m_stall = 0;
    trapped = 1'b0;
    repeat (3) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      #1;
      check("rst_ctl", 32'(act), 32'd0);
      check("rst_cnt", {retired_cnt, stall_cnt}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_ctl", 32'(act), 32'd0);
    @(posedge clk);
    #1;
    check("rel_state", 32'(state), 32'd1);
    check("rel_fetch", {mem_req, iord}, 32'b10);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [2:0] fn, input logic eq, input int wf, input int wm);
    ctl_t x;
    bit taken;
    func = fn;
    for (int i = 0; i < wf; i++) begin
      x = '0; x.st = 3'd1; x.req = 1'b1;
      cyc(x, 1'b0, 4'($urandom), 1'($urandom), "fetch_wait");
    end
    x = '0; x.st = 3'd1; x.req = 1'b1; x.irw = 1'b1; x.pcw = 1'b1;
    cyc(x, 1'b1, 4'($urandom), 1'($urandom), "fetch");
    x = '0; x.st = 3'd2;
    if (op == 4'd15) begin
      x.pcw = 1'b1; x.pcsrc = 2'd2; x.done = 1'b1;
      cyc(x, 1'($urandom), op, 1'($urandom), "decode_j");
      return;
    end
    cyc(x, 1'($urandom), op, 1'($urandom), "decode");
    if (is_illegal(op, fn)) begin
      for (int i = 0; i < 6; i++) begin
        x = '0; x.st = 3'd6; x.ill = 1'b1;
        cyc(x, 1'($urandom), op, 1'($urandom), "trap");
      end
      trapped = 1'b1;
      return;
    end
    x = '0; x.st = 3'd3; x.alu = alu_of(op, fn);
    x.asrcb = (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8});
    if (op == 4'd9 || op == 4'd10) begin
      taken = (op == 4'd9) ? eq : !eq;
      x.pcw = taken; x.pcsrc = taken ? 2'd1 : 2'd0; x.done = 1'b1;
      cyc(x, 1'($urandom), op, eq, "exec_br");
      return;
    end
    cyc(x, 1'($urandom), op, eq, "exec");
    if (op == 4'd7 || op == 4'd8) begin
      x = '0; x.st = 3'd4; x.req = 1'b1; x.iord = 1'b1; x.we = (op == 4'd8);
      for (int i = 0; i < wm; i++) cyc(x, 1'b0, op, 1'($urandom), "mem_wait");
      x.done = (op == 4'd8);
      cyc(x, 1'b1, op, 1'($urandom), "mem");
      if (op == 4'd8) return;
    end
    x = '0; x.st = 3'd5; x.rw = 1'b1; x.rdst = (op == 4'd0); x.m2r = (op == 4'd7); x.done = 1'b1;
    cyc(x, 1'($urandom), op, 1'($urandom), "wb");
  endtask

  logic [3:0] legal_ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};

  initial begin
    logic [3:0] op;
    logic [2:0] fn;
    ctl_t x;
    rst = 1'b0; opcode = '0; func = '0; equal = 1'b0; mem_ready = 1'b0;
    do_reset();

    run_instr(4'd0, 3'd0, 1'b0, 0, 0);
    run_instr(4'd7, 3'd0, 1'b0, 3, 2);
    run_instr(4'd9, 3'd0, 1'b1, 0, 0);
    run_instr(4'd10, 3'd0, 1'b1, 0, 0);
    run_instr(4'd8, 3'd0, 1'b0, 1, 1);
    run_instr(4'd15, 3'd0, 1'b0, 0, 0);

    run_instr(4'd12, 3'd0, 1'b0, 0, 0);
    do_reset();
    run_instr(4'd0, 3'd7, 1'b0, 1, 0);
    do_reset();

    for (int i = 0; i < 20; i++) run_instr(4'd0, 3'($urandom_range(0, 6)), 1'b0, 1, 0);

    // abort a store mid-MEMACC: write strobe must drop with the reset, not at an edge
    func = 3'd0;
    x = '0; x.st = 3'd1; x.req = 1'b1; x.irw = 1'b1; x.pcw = 1'b1;
    cyc(x, 1'b1, 4'd8, 1'b0, "ab_fetch");
    x = '0; x.st = 3'd2;
    cyc(x, 1'b0, 4'd8, 1'b0, "ab_decode");
    x = '0; x.st = 3'd3; x.asrcb = 1'b1;
    cyc(x, 1'b0, 4'd8, 1'b0, "ab_exec");
    x = '0; x.st = 3'd4; x.req = 1'b1; x.iord = 1'b1; x.we = 1'b1;
    cyc(x, 1'b0, 4'd8, 1'b0, "ab_mem");
    #1 rst = 1'b0;
    #1 check("abort_ctl", 32'(act), 32'd0);
    do_reset();

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 19) == 0) op = 4'($urandom);
      else op = legal_ops[$urandom_range(0, 9)];
      fn = 3'($urandom_range(0, 6));
      if (op == 4'd0 && $urandom_range(0, 9) == 0) fn = 3'd7;
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      if (trapped) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
